// File: rtl/interrupt_ctrl.sv
// Interrupt controller: synchronizes 16 external request lines, latches rising edges
// into a pending register, counts coalesced edges and ORs a reloadable timer tick into one source.
module interrupt_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_BIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] irq_in,
    input  logic        stall,
    input  logic        tmr_wen,
    input  logic [31:0] tmr_wdata,
    output logic [15:0] interrupts,
    output logic [7:0]  lost_count,
    output logic [31:0] timer_count
);

    logic [SYNC_STAGES-1:0][15:0] sync_q, sync_d;
    logic [15:0] prev_q;
    logic [15:0] pending_q, pending_d;
    logic [7:0]  lost_q, lost_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] reload_q, reload_d;
    logic [15:0] edge_s;
    logic [15:0] delivered_s;
    logic        tick_s;
    logic        any_lost_s;

    // Synchronizer chain shift: stage 0 samples the raw asynchronous lines.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Timer tick, rising-edge detection and delivery mask.
    always_comb begin
        tick_s = (reload_q != 32'd0) && (counter_q == 32'd1) && !tmr_wen;
        edge_s = sync_q[SYNC_STAGES-1] & ~prev_q;
        edge_s[TIMER_BIT] = edge_s[TIMER_BIT] | tick_s;
        if (stall) begin
            delivered_s = 16'h0000;
        end else begin
            delivered_s = pending_q;
        end
    end

    // Pending update and saturating count of edges that hit an undelivered pending bit.
    always_comb begin
        pending_d  = (pending_q & ~delivered_s) | edge_s;
        any_lost_s = |(edge_s & pending_q & ~delivered_s);
        if (any_lost_s && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end else begin
            lost_d = lost_q;
        end
    end

    // Timer next state: a write wins over counting; reload 0 disables the timer.
    always_comb begin
        counter_d = counter_q;
        reload_d  = reload_q;
        if (tmr_wen) begin
            counter_d = tmr_wdata;
            reload_d  = tmr_wdata;
        end else if (reload_q == 32'd0) begin
            counter_d = counter_q;
        end else if (counter_q <= 32'd1) begin
            counter_d = reload_q;
        end else begin
            counter_d = counter_q - 32'd1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 16'h0000;
            pending_q <= 16'h0000;
            lost_q    <= 8'd0;
            counter_q <= 32'd0;
            reload_q  <= 32'd0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            lost_q    <= lost_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
        end
    end

    assign interrupts  = pending_q;
    assign lost_count  = lost_q;
    assign timer_count = counter_q;

endmodule
